// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the bus round-robin arbiter family.
// Optional timeout abort is enabled with BUS_ARB_TIMEOUT_EN (see bus_rr_arbiter).
package bus_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // Index width that never collapses to zero bits for a single requester.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bus_rr_arbiter_if.sv
// Master-side request/response bundle and slave-side bus of the round-robin arbiter.
// The m_err lines only carry pulses when BUS_ARB_TIMEOUT_EN is defined.
interface bus_rr_arbiter_if
    import bus_arb_pkg::*;
#(
    parameter int N_MASTERS = 4,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF
);
    localparam int IDX_W = clog2_min1(N_MASTERS);

    logic [N_MASTERS-1:0]        m_valid;
    logic [N_MASTERS-1:0]        m_read;
    logic [N_MASTERS*ADDR_W-1:0] m_addr;
    logic [N_MASTERS*DATA_W-1:0] m_wdata;
    logic [N_MASTERS-1:0]        m_ready;
    logic [DATA_W-1:0]           m_rdata;
    logic [N_MASTERS-1:0]        m_err;

    logic                        s_valid;
    logic                        s_read;
    logic [ADDR_W-1:0]           s_addr;
    logic [DATA_W-1:0]           s_wdata;
    logic                        s_ready;
    logic [DATA_W-1:0]           s_rdata;

    logic [IDX_W-1:0]            grant_id;
    logic                        busy;

    // Initiator view: drives requests, receives completions.
    modport master (
        output m_valid, m_read, m_addr, m_wdata,
        input  m_ready, m_rdata, m_err
    );

    // Register-slave view.
    modport slave (
        input  s_valid, s_read, s_addr, s_wdata,
        output s_ready, s_rdata
    );

    // The arbiter sits between the two views.
    modport arb (
        input  m_valid, m_read, m_addr, m_wdata, s_ready, s_rdata,
        output m_ready, m_rdata, m_err, s_valid, s_read, s_addr, s_wdata,
        output grant_id, busy
    );

endinterface

// File: rtl/bus_rr_picker.sv
// Combinational round-robin pick: first asserted req scanning upward from last+1,
// wrapping modulo N. Shared by several arbiters.
module bus_rr_picker
    import bus_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = clog2_min1(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Scan farthest offset first so the nearest requester after 'last' wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int off = N; off >= 1; off--) begin
            cand = int'(last) + off;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IDX_W'(cand);
            if (req[cand_idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one register-slave bus among N_MASTERS initiators,
// one transaction in flight. Define BUS_ARB_TIMEOUT_EN to abort stalled transfers.
module bus_rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int N_MASTERS      = 4,
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic           clk,
    input  logic           reset,
    bus_rr_arbiter_if.arb  bus
);

    localparam int IDX_W = clog2_min1(N_MASTERS);

    arb_state_t        state_reg;
    logic              s_valid_reg;
    logic              s_read_reg;
    logic [ADDR_W-1:0] s_addr_reg;
    logic [DATA_W-1:0] s_wdata_reg;
    logic [IDX_W-1:0]  grant_id_reg;
    logic              busy_reg;

    logic              gnt_valid;
    logic [IDX_W-1:0]  gnt_idx;
    logic              busy_done;
    logic              busy_end;

    logic [ADDR_W-1:0] addr_arr  [N_MASTERS];
    logic [DATA_W-1:0] wdata_arr [N_MASTERS];

    bus_rr_picker #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req       (bus.m_valid),
        .last      (grant_id_reg),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Completion is suppressed while reset is high so a reset mid-transfer never acks.
    assign busy_done = (state_reg == ARB_BUSY) && bus.s_ready && !reset;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_reg;
    logic             tmo_hit;
    logic             tmo_abort;

    assign tmo_hit   = !bus.s_ready && (tmo_reg == TMO_W'(TIMEOUT_CYCLES - 1));
    assign tmo_abort = (state_reg == ARB_BUSY) && tmo_hit && !reset;
    assign busy_end  = bus.s_ready || tmo_hit;
`else
    assign busy_end  = bus.s_ready;
`endif

    generate
        for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_master
            assign addr_arr[gi]    = bus.m_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi]   = bus.m_wdata[gi*DATA_W +: DATA_W];
            assign bus.m_ready[gi] = busy_done && (grant_id_reg == IDX_W'(gi));
`ifdef BUS_ARB_TIMEOUT_EN
            assign bus.m_err[gi]   = tmo_abort && (grant_id_reg == IDX_W'(gi));
`else
            assign bus.m_err[gi]   = 1'b0;
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ARB_IDLE;
            s_valid_reg  <= 1'b0;
            s_read_reg   <= 1'b0;
            s_addr_reg   <= '0;
            s_wdata_reg  <= '0;
            grant_id_reg <= IDX_W'(N_MASTERS - 1);
            busy_reg     <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
            tmo_reg      <= '0;
`endif
        end else begin
            case (state_reg)
                ARB_IDLE: begin
                    if (gnt_valid) begin
                        state_reg    <= ARB_BUSY;
                        s_valid_reg  <= 1'b1;
                        busy_reg     <= 1'b1;
                        grant_id_reg <= gnt_idx;
                        s_read_reg   <= bus.m_read[gnt_idx];
                        s_addr_reg   <= addr_arr[gnt_idx];
                        s_wdata_reg  <= wdata_arr[gnt_idx];
`ifdef BUS_ARB_TIMEOUT_EN
                        tmo_reg      <= '0;
`endif
                    end
                end
                ARB_BUSY: begin
                    // grant_id keeps the last winner, so rotation resumes after it.
                    if (busy_end) begin
                        state_reg   <= ARB_IDLE;
                        s_valid_reg <= 1'b0;
                        busy_reg    <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
                        tmo_reg     <= '0;
                    end else begin
                        tmo_reg     <= tmo_reg + 1'b1;
`endif
                    end
                end
                default: begin
                    state_reg <= ARB_IDLE;
                end
            endcase
        end
    end

    assign bus.s_valid  = s_valid_reg;
    assign bus.s_read   = s_read_reg;
    assign bus.s_addr   = s_addr_reg;
    assign bus.s_wdata  = s_wdata_reg;
    assign bus.grant_id = grant_id_reg;
    assign bus.busy     = busy_reg;
    assign bus.m_rdata  = bus.s_rdata;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter: directed scenarios followed by random traffic,
// checked against a transaction-level round-robin model (timeout modelled under BUS_ARB_TIMEOUT_EN).
module tb_bus_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bus_rr_arbiter_if #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    bus_rr_arbiter #(
        .N_MASTERS      (N),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Master-side request holders
    logic          pend  [N];
    logic          p_rd  [N];
    logic [AW-1:0] p_adr [N];
    logic [DW-1:0] p_wd  [N];

    // Reference model state
    logic          mdl_busy;
    int            mdl_gid;
    logic          mdl_read;
    logic [AW-1:0] mdl_addr;
    logic [DW-1:0] mdl_wdata;
    int            mdl_tmo;
    logic          mdl_granted;
    int            waited [N];
    logic [N-1:0]  done_mask;
    int            slave_wait;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] req, input int last);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.m_valid[i]            = pend[i];
            bus.m_read[i]             = p_rd[i];
            bus.m_addr[i*AW +: AW]    = p_adr[i];
            bus.m_wdata[i*DW +: DW]   = p_wd[i];
        end
    endtask

    task automatic req(input int i, input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pend[i] = 1'b1; p_rd[i] = rd; p_adr[i] = a; p_wd[i] = d;
        drive();
    endtask

    // One clock: check combinational responses, advance the model, check registered state.
    task automatic cycle();
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_err;
        int           w;
        #1;
        exp_rdy = '0;
        exp_err = '0;
        if (mdl_busy && bus.s_ready && !reset) exp_rdy[mdl_gid] = 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
        if (mdl_busy && !bus.s_ready && !reset && mdl_tmo == TO - 1) exp_err[mdl_gid] = 1'b1;
`endif
        chk("m_ready", 64'(bus.m_ready), 64'(exp_rdy));
        chk("m_err",   64'(bus.m_err),   64'(exp_err));
        chk("m_rdata", 64'(bus.m_rdata), 64'(bus.s_rdata));
        done_mask = exp_rdy | exp_err;

        @(posedge clk);
        mdl_granted = 1'b0;
        if (reset) begin
            mdl_busy = 1'b0; mdl_gid = N - 1; mdl_read = 1'b0;
            mdl_addr = '0; mdl_wdata = '0; mdl_tmo = 0;
            for (int i = 0; i < N; i++) waited[i] = 0;
        end else if (!mdl_busy) begin
            w = rr_pick(bus.m_valid, mdl_gid);
            if (w >= 0) begin
                for (int j = 0; j < N; j++) if (j != w && bus.m_valid[j]) waited[j]++;
                chk("starvation_bound", 64'(waited[w] <= N - 1), 64'(1));
                waited[w]   = 0;
                mdl_busy    = 1'b1;
                mdl_granted = 1'b1;
                mdl_gid     = w;
                mdl_read    = p_rd[w];
                mdl_addr    = p_adr[w];
                mdl_wdata   = p_wd[w];
                mdl_tmo     = 0;
            end
        end else if (bus.s_ready) begin
            mdl_busy = 1'b0;
            mdl_tmo  = 0;
`ifdef BUS_ARB_TIMEOUT_EN
        end else if (mdl_tmo == TO - 1) begin
            mdl_busy = 1'b0;
            mdl_tmo  = 0;
`endif
        end else begin
            mdl_tmo++;
        end
        #1;
        chk("s_valid",  64'(bus.s_valid),  64'(mdl_busy));
        chk("busy",     64'(bus.busy),     64'(mdl_busy));
        chk("grant_id", 64'(bus.grant_id), 64'(mdl_gid));
        chk("s_read",   64'(bus.s_read),   64'(mdl_read));
        chk("s_addr",   64'(bus.s_addr),   64'(mdl_addr));
        chk("s_wdata",  64'(bus.s_wdata),  64'(mdl_wdata));
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; p_rd[i] = 1'b0; p_adr[i] = '0; p_wd[i] = '0; waited[i] = 0;
        end
        drive();
        bus.s_ready = 1'b0;
        bus.s_rdata = '0;
        mdl_busy = 1'b0; mdl_gid = N - 1; mdl_read = 1'b0; mdl_addr = '0;
        mdl_wdata = '0; mdl_tmo = 0; mdl_granted = 1'b0; done_mask = '0; slave_wait = 0;

        // Reset state
        cycle(); cycle();
        chk("rst_grant_id", 64'(bus.grant_id), 64'(N - 1));
        chk("rst_s_valid",  64'(bus.s_valid),  64'(0));

        // Single read from master 0, slave answers on the second busy cycle
        reset = 1'b0;
        req(0, 1'b1, 32'h10, 32'h0);
        cycle();
        chk("tp1_s_valid", 64'(bus.s_valid), 64'(1));
        chk("tp1_s_addr",  64'(bus.s_addr),  64'h10);
        cycle();
        bus.s_ready = 1'b1; bus.s_rdata = 32'hCAFEBABE;
        #1;
        chk("tp1_m_ready", 64'(bus.m_ready), 64'(4'b0001));
        chk("tp1_m_rdata", 64'(bus.m_rdata), 64'hCAFEBABE);
        cycle();
        bus.s_ready = 1'b0; pend[0] = 1'b0; drive();
        cycle();
        chk("tp1_s_valid_low", 64'(bus.s_valid), 64'(0));

        // All four masters request continuously: grants rotate 0,1,2,3,0
        reset = 1'b1; cycle(); reset = 1'b0;
        for (int i = 0; i < N; i++) req(i, 1'b1, 32'(32'h1000 + i * 4), 32'h0);
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("tp2_grant_order", 64'(bus.grant_id), 64'(k % N));
            bus.s_ready = 1'b1; bus.s_rdata = $urandom;
            cycle();
            bus.s_ready = 1'b0;
        end
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        drive();

        // Master 2 write arrives while master 1 is in flight
        req(1, 1'b0, 32'h100, 32'h11111111);
        cycle();
        chk("tp3_grant1", 64'(bus.grant_id), 64'(1));
        req(2, 1'b0, 32'h200, 32'hDEADBEEF);
        cycle();
        chk("tp3_hold_wdata", 64'(bus.s_wdata), 64'h11111111);
        chk("tp3_hold_addr",  64'(bus.s_addr),  64'h100);
        bus.s_ready = 1'b1;
        cycle();
        bus.s_ready = 1'b0; pend[1] = 1'b0; drive();
        cycle();
        chk("tp3_grant2",    64'(bus.grant_id), 64'(2));
        chk("tp3_m2_wdata",  64'(bus.s_wdata),  64'hDEADBEEF);

        // Reset while busy, with a simultaneous slave ready that must not ack
        reset = 1'b1; bus.s_ready = 1'b1;
        #1;
        chk("tp4_no_m_ready", 64'(bus.m_ready), 64'(0));
        cycle();
        chk("tp4_s_valid", 64'(bus.s_valid),  64'(0));
        chk("tp4_busy",    64'(bus.busy),     64'(0));
        chk("tp4_grant",   64'(bus.grant_id), 64'(N - 1));
        reset = 1'b0; bus.s_ready = 1'b0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        drive();

        // Stray slave ready while idle
        bus.s_ready = 1'b1; bus.s_rdata = 32'h5A5A5A5A;
        cycle();
        chk("tp6_idle_busy", 64'(bus.busy), 64'(0));
        bus.s_ready = 1'b0;

        // Random traffic
        for (int t = 0; t < 800; t++) begin
            reset = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < N; i++) begin
                if (done_mask[i]) pend[i] = 1'b0;
                if (!pend[i] && $urandom_range(0, 2) == 0)
                    req(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
            end
            drive();
            if (mdl_busy) begin
                if (mdl_granted) slave_wait = $urandom_range(0, 2);
                if (slave_wait == 0) begin
                    bus.s_ready = 1'b1; bus.s_rdata = $urandom;
                end else begin
                    bus.s_ready = 1'b0; slave_wait--;
                end
            end else begin
                bus.s_ready = ($urandom_range(0, 9) == 0);
                bus.s_rdata = $urandom;
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
- Shares one slave-side bus (valid/read/addr/wdata -> ready/rdata) between N_MASTERS requesters.
- Round-robin grant, one outstanding transaction at a time.
- Request is registered at grant and presented to the slave until its single-cycle ready pulse. The pulse and rdata are routed back to the granted master.
- Sits between the CPU-side initiators and the register slaves on the parameterized communication bus.

Parameters:
- N_MASTERS, 4, number of requesters (>=1)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYCLES, 16, BUSY cycles without s_ready before abort (used only with the optional feature)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- m_valid  in  N_MASTERS  per-master request
- m_read  in  N_MASTERS  1=read, 0=write
- m_addr  in  N_MASTERS*ADDR_W  packed, master i at [i*ADDR_W +: ADDR_W]
- m_wdata  in  N_MASTERS*DATA_W  packed, same layout
- m_ready  out  N_MASTERS  completion pulse, one-hot or zero
- m_rdata  out  DATA_W  broadcast read data, valid with m_ready
- m_err  out  N_MASTERS  timeout-abort pulse (tied 0 without the optional feature)
- s_valid  out  1  request to slave
- s_read  out  1  direction to slave
- s_addr  out  ADDR_W  address to slave
- s_wdata  out  DATA_W  write data to slave
- s_ready  in  1  slave completion pulse (one cycle)
- s_rdata  in  DATA_W  slave read data, valid while s_ready=1
- grant_id  out  $clog2(N_MASTERS) (min 1)  index of current/last grant
- busy  out  1  transaction in flight

Behaviour:
- Clocking: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - state=ARB_IDLE
  - s_valid=0, s_read=0, s_addr=0, s_wdata=0
  - grant_id=N_MASTERS-1, so master 0 has top priority first
  - busy=0, m_ready=0, m_err=0
  - timeout counter=0
- States:
  - ARB_IDLE: if any m_valid, pick a winner and move to ARB_BUSY.
  - ARB_BUSY: s_valid=1, waiting for s_ready.
- Round-robin pick (combinational): first asserted m_valid scanning from grant_id+1 upward, wrapping modulo N_MASTERS. With N_MASTERS=1 the winner is always 0.
- On grant (IDLE->BUSY edge), all registered:
  - winner's read/addr/wdata captured into s_read/s_addr/s_wdata
  - grant_id<=winner, s_valid<=1, busy<=1
- ARB_BUSY with s_ready=1:
  - m_ready[grant_id]=1 and m_rdata=s_rdata, combinational in the same cycle.
  - Next edge: s_valid<=0, busy<=0, state<=ARB_IDLE.
  - s_valid is guaranteed low on the cycle the slave returns to its idle state, so no double-issue.
- m_rdata=s_rdata at all times. Masters qualify it with m_ready.
- Master contract: hold m_valid and request fields until m_ready. Drop m_valid the cycle after m_ready, unless issuing a new request.
  - m_valid dropped during BUSY is ignored; the transaction completes and m_ready still pulses.
- Latency: grant 1 cycle after m_valid seen in IDLE. With a standard 2-cycle slave, m_ready 3 cycles after m_valid. Back-to-back grants are separated by one IDLE cycle.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers stay pending with no starvation; max wait is N_MASTERS-1 transactions.
- s_ready while in IDLE: ignored; no m_ready is generated.
- Reset mid-transaction: all state returns to reset values at the next edge and no m_ready is emitted. The slave shares the same reset.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- Defined:
  - Counter increments every BUSY cycle with s_ready=0.
  - When it reaches TIMEOUT_CYCLES: m_err[grant_id] pulses one cycle, s_valid<=0, state<=ARB_IDLE, counter<=0, rotation advances.
  - s_ready on the same cycle as expiry wins: normal completion, no m_err.
- Undefined: no counter, m_err tied 0, BUSY waits indefinitely.

Decomposition:
- Package bus_arb_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_BUSY}
  - default width constants (ADDR_W_DEF=32, DATA_W_DEF=32)
  - function clog2_min1
- Sub-module bus_rr_picker: purely combinational. Inputs req[N], last[idx]; outputs gnt_valid, gnt_idx. Reused by other arbiters.

Test Plan:
- Reset, then m_valid=0001 read addr 0x10 -> s_valid at cycle 1 with s_addr=0x10; m_ready=0001 at cycle 3 with m_rdata=0xCAFEBABE; s_valid=0 at cycle 4.
- All four masters assert continuously -> grant order 0,1,2,3,0; each m_ready one-hot to the matching index.
- Master 2 write wdata 0xDEADBEEF while master 1 is in flight -> s_wdata captured only at master 2's grant; master 1's fields unchanged during its BUSY.
- reset asserted while BUSY -> next edge s_valid=0, busy=0, grant_id=N_MASTERS-1; no m_ready pulse.
- With BUS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, slave stub never readies -> m_err[0] pulses after 4 BUSY cycles, then master 1 is granted.
- Stray s_ready pulse in IDLE -> m_ready stays 0, state stays IDLE.
